// File: rtl/mc14500b_trace_pkg.sv
// Shared types for the mc14500b OUTPUT/TRACE capture UART.
// Defining TRACE_TIMESTAMP_EN adds a 16-bit timestamp to each record and two bytes to each frame.
package mc14500b_trace_pkg;

`ifdef TRACE_TIMESTAMP_EN
  localparam int FRAME_BYTES = 5;

  typedef struct packed {
    logic [15:0] ts;
    logic [7:0]  out_byte;
    logic [7:0]  trace_byte;
  } record_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_TSH    = 3'd2,
    ST_TSL    = 3'd3,
    ST_OUTB   = 3'd4,
    ST_TRACEB = 3'd5
  } fsm_state_t;
`else
  localparam int FRAME_BYTES = 3;

  typedef struct packed {
    logic [7:0] out_byte;
    logic [7:0] trace_byte;
  } record_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_OUTB   = 3'd4,
    ST_TRACEB = 3'd5
  } fsm_state_t;
`endif

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter, LSB first; done pulses in the last cycle of STOP so the next byte
// can be loaded on the same edge with no gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] data,
  input  logic       start,
  output logic       TX,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  tx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg, sh_nxt;
  logic          tick;

  assign tick = (cnt == '0);
  assign done = (state == T_STOP) && tick;
  assign busy = (state != T_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = tick ? BIT_LAST : cnt - 1'b1;
    bit_nxt   = bit_idx;
    sh_nxt    = shreg;
    case (state)
      T_IDLE:  cnt_nxt = cnt;
      T_START: if (tick) state_nxt = T_DATA;
      T_DATA: begin
        if (tick) begin
          sh_nxt  = shreg >> 1;
          bit_nxt = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_nxt = T_STOP;
        end
      end
      T_STOP:  if (tick) state_nxt = T_IDLE;
      default: state_nxt = T_IDLE;
    endcase
    if (start && ((state == T_IDLE) || done)) begin
      state_nxt = T_START;
      cnt_nxt   = BIT_LAST;
      sh_nxt    = data;
      bit_nxt   = 3'd0;
    end
  end

  // TX is retimed from the current bit state, so the line trails the state by one clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= T_IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      TX      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= sh_nxt;
      TX      <= (state == T_START) ? 1'b0 : (state == T_DATA) ? shreg[0] : 1'b1;
    end
  end

endmodule

// File: rtl/mc14500b_trace_uart.sv
// Records every change of {OUTPUT,TRACE} into a FIFO and streams each record as a UART frame.
// Optional TRACE_TIMESTAMP_EN: a 16-bit cycle stamp is stored per record and sent after SYNC_BYTE.
// RST is expected to be released synchronously by the board-level reset synchroniser.
//
// state     | meaning
// ST_IDLE   | waiting for a record; pops it and starts SYNC_BYTE
// ST_SYNC   | SYNC_BYTE on the line
// ST_TSH    | timestamp high byte on the line (timestamp build only)
// ST_TSL    | timestamp low byte on the line (timestamp build only)
// ST_OUTB   | OUTPUT byte on the line
// ST_TRACEB | TRACE byte on the line; back to idle when it completes
module mc14500b_trace_uart
  import mc14500b_trace_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 104,
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [7:0] OUTPUT,
  input  logic [7:0] TRACE,
  output logic       TX,
  output logic       BUSY,
  output logic       OVERFLOW
);

  localparam int AW = $clog2(FIFO_DEPTH);

  record_t     mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty;
  logic [15:0] last;
  logic        first_flag;
  record_t     sample, hold;
  logic        capture, push, pop;
  fsm_state_t  state, state_nxt;
  logic        tx_start, tx_busy, tx_done;
  logic [7:0]  tx_data;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign capture = EN && (first_flag || ({OUTPUT, TRACE} != last));
  assign push    = capture && !full;

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ts_cnt <= 16'd0;
    else     ts_cnt <= ts_cnt + 16'd1;
  end
`endif

  always_comb begin
    sample            = '0;
    sample.out_byte   = OUTPUT;
    sample.trace_byte = TRACE;
`ifdef TRACE_TIMESTAMP_EN
    sample.ts         = ts_cnt;
`endif
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= sample;
  end

  // A dropped record still updates last: the change is lost, not retried.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last       <= 16'd0;
      first_flag <= 1'b1;
      OVERFLOW   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      hold       <= '0;
      state      <= ST_IDLE;
      BUSY       <= 1'b0;
    end else begin
      if (capture) begin
        last       <= {OUTPUT, TRACE};
        first_flag <= 1'b0;
        if (full) OVERFLOW <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold   <= mem[rd_ptr[AW-1:0]];
      end
      state <= state_nxt;
      BUSY  <= !empty || (state != ST_IDLE) || tx_busy;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_start  = 1'b0;
    tx_data   = SYNC_BYTE;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          tx_start  = 1'b1;
          state_nxt = ST_SYNC;
        end
      end
`ifdef TRACE_TIMESTAMP_EN
      ST_SYNC: begin
        if (tx_done) begin
          tx_start  = 1'b1;
          tx_data   = hold.ts[15:8];
          state_nxt = ST_TSH;
        end
      end
      ST_TSH: begin
        if (tx_done) begin
          tx_start  = 1'b1;
          tx_data   = hold.ts[7:0];
          state_nxt = ST_TSL;
        end
      end
      ST_TSL: begin
        if (tx_done) begin
          tx_start  = 1'b1;
          tx_data   = hold.out_byte;
          state_nxt = ST_OUTB;
        end
      end
`else
      ST_SYNC: begin
        if (tx_done) begin
          tx_start  = 1'b1;
          tx_data   = hold.out_byte;
          state_nxt = ST_OUTB;
        end
      end
`endif
      ST_OUTB: begin
        if (tx_done) begin
          tx_start  = 1'b1;
          tx_data   = hold.trace_byte;
          state_nxt = ST_TRACEB;
        end
      end
      ST_TRACEB: if (tx_done) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .CLK   (CLK),
    .RST   (RST),
    .data  (tx_data),
    .start (tx_start),
    .TX    (TX),
    .busy  (tx_busy),
    .done  (tx_done)
  );

endmodule

// File: tb/tb_mc14500b_trace_uart.sv
// Bench for mc14500b_trace_uart: frame-level reference model checked every cycle, a UART
// receiver on TX, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_mc14500b_trace_uart;

  localparam int C = 4;
  localparam int D = 4;
`ifdef TRACE_TIMESTAMP_EN
  localparam int FB = 5;
`else
  localparam int FB = 3;
`endif
  localparam int FLEN = FB * 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [7:0] out_bus = 8'h00;
  logic [7:0] trace_bus = 8'h00;
  logic       tx, busy, ovf;

  int n_pass  = 0;
  int n_total = 0;

  mc14500b_trace_uart #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .SYNC_BYTE(8'hA5)) dut (
    .CLK(clk), .RST(rst), .EN(en), .OUTPUT(out_bus), .TRACE(trace_bus),
    .TX(tx), .BUSY(busy), .OVERFLOW(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: record queue plus a frame engine busy for FLEN*C cycles after each pop.
  logic [31:0] m_q[$];
  logic [15:0] m_last = 16'h0;
  logic [15:0] m_ts = 16'h0;
  bit          m_first = 1'b1, m_active = 1'b0, m_pvalid = 1'b0;
  int          m_edge = 0, m_p = 0;
  bit          m_bits[FLEN];
  logic        exp_tx = 1'b1, exp_busy = 1'b0, exp_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin : model_step
    bit          pre_nonempty, pre_active, pre_full;
    logic [15:0] s;
    logic [31:0] rec;
    logic [7:0]  fb[FB];
    if (rst) begin
      m_q.delete();
      m_last = 16'h0; m_ts = 16'h0; m_first = 1'b1;
      m_active = 1'b0; m_pvalid = 1'b0; m_edge = 0;
      exp_tx = 1'b1; exp_busy = 1'b0; exp_ovf = 1'b0;
    end else begin
      m_edge++;
      pre_nonempty = (m_q.size() != 0);
      pre_active   = m_active;
      pre_full     = (m_q.size() == D);
      exp_busy     = pre_nonempty || pre_active;
      if (m_active && m_edge == m_p + FLEN * C) m_active = 1'b0;
      if (!pre_active && pre_nonempty) begin
        rec = m_q.pop_front();
        m_p = m_edge; m_active = 1'b1; m_pvalid = 1'b1;
        fb[0] = 8'hA5;
`ifdef TRACE_TIMESTAMP_EN
        fb[1] = rec[31:24];
        fb[2] = rec[23:16];
`endif
        fb[FB-2] = rec[15:8];
        fb[FB-1] = rec[7:0];
        for (int i = 0; i < FB; i++) begin
          m_bits[i*10] = 1'b0;
          for (int j = 0; j < 8; j++) m_bits[i*10+1+j] = fb[i][j];
          m_bits[i*10+9] = 1'b1;
        end
      end
      s = {out_bus, trace_bus};
      if (en && (m_first || s != m_last)) begin
        m_first = 1'b0;
        m_last  = s;
        if (pre_full) exp_ovf = 1'b1;
        else m_q.push_back({m_ts, s});
      end
      m_ts++;
      if (m_pvalid && m_edge >= m_p + 1 && m_edge <= m_p + FLEN * C)
        exp_tx = m_bits[(m_edge - m_p - 1) / C];
      else
        exp_tx = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("tx_cycle", {31'd0, tx}, {31'd0, exp_tx});
    check("busy_cycle", {31'd0, busy}, {31'd0, exp_busy});
    check("overflow_cycle", {31'd0, ovf}, {31'd0, exp_ovf});
  end

  // UART receiver: detects the start bit at a negedge and samples each bit C negedges apart.
  logic [7:0] rx_q[$];
  bit         rx_on = 1'b0;
  int         rx_n = 0;
  logic [7:0] rx_sh = 8'h0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      rx_on = 1'b0; rx_n = 0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin rx_on = 1'b1; rx_n = 0; end
    end else begin
      rx_n++;
      if (rx_n % C == 0 && rx_n <= 8 * C) rx_sh[rx_n/C - 1] = tx;
      if (rx_n == 9 * C) begin rx_q.push_back(rx_sh); rx_on = 1'b0; end
    end
  end

  task automatic wait_idle(input string name, input int limit);
    int n;
    repeat (3) @(negedge clk);
    n = 0;
    while (busy && n < limit) begin @(negedge clk); n++; end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic expect_frame(input string name, input int idx, input logic [7:0] o, input logic [7:0] t);
    int base;
    base = idx * FB;
    if (rx_q.size() < base + FB) begin
      check({name, "_frame_present"}, rx_q.size(), base + FB);
    end else begin
      check({name, "_sync"}, {24'd0, rx_q[base]}, 32'h0000_00A5);
      check({name, "_out"}, {24'd0, rx_q[base+FB-2]}, {24'd0, o});
      check({name, "_trace"}, {24'd0, rx_q[base+FB-1]}, {24'd0, t});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);

    // First sample after reset always records, even though it equals the cleared last value.
    @(negedge clk); en = 1'b1;
    @(negedge clk); check("t1_tx_k", {31'd0, tx}, 32'd1);
    @(negedge clk); check("t1_tx_k1", {31'd0, tx}, 32'd1);
    @(negedge clk); check("t1_tx_fall", {31'd0, tx}, 32'd0);
    n = 0;
    while (busy && n < 1000) begin @(negedge clk); n++; end
    check("t1_busy_cycles", n, FLEN * C);
    check("t1_nbytes", rx_q.size(), FB);
    expect_frame("t1", 0, 8'h00, 8'h00);
    rx_q.delete();

    repeat (5) @(negedge clk);
    check("t2_no_frame_unchanged", rx_q.size(), 0);
    out_bus = 8'h3C;
    repeat (10) @(negedge clk);
    trace_bus = 8'h81;
    wait_idle("t2", 2000);
    check("t2_nbytes", rx_q.size(), 2 * FB);
    expect_frame("t2a", 0, 8'h3C, 8'h00);
    expect_frame("t2b", 1, 8'h3C, 8'h81);
    rx_q.delete();

    // Six back-to-back changes: one popped at once, four fill the FIFO, the sixth is dropped.
    for (int i = 1; i <= 6; i++) begin
      out_bus = 8'(8'h10 * i);
      trace_bus = 8'(i);
      @(negedge clk);
    end
    check("t3_ovf_set", {31'd0, ovf}, 32'd1);
    wait_idle("t3", 4000);
    check("t3_ovf_sticky", {31'd0, ovf}, 32'd1);
    check("t3_nbytes", rx_q.size(), 5 * FB);
    expect_frame("t3_first", 0, 8'h10, 8'h01);
    expect_frame("t3_last", 4, 8'h50, 8'h05);
    rx_q.delete();

    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      out_bus = 8'(8'hE0 + i);
      trace_bus = 8'(8'h70 - i);
      @(negedge clk);
    end
    out_bus = 8'h60; trace_bus = 8'h06;
    @(negedge clk); en = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_no_busy", {31'd0, busy}, 32'd0);
    check("t4_no_frame", rx_q.size(), 0);
    out_bus = 8'h77;
    wait_idle("t4", 2000);
    check("t4_nbytes", rx_q.size(), FB);
    expect_frame("t4", 0, 8'h77, 8'h06);
    rx_q.delete();

    // Reset while the OUTPUT byte (all zero bits) is on the line.
    out_bus = 8'h00; trace_bus = 8'h55;
    @(posedge clk);
    repeat ((FB - 2) * 10 * C + 10) @(posedge clk);
    #1;
    check("t5_tx_low_before_rst", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    #1;
    check("t5_tx_rst", {31'd0, tx}, 32'd1);
    check("t5_busy_rst", {31'd0, busy}, 32'd0);
    check("t5_ovf_rst", {31'd0, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    wait_idle("t5", 2000);
    check("t5_nbytes", rx_q.size(), FB);
    expect_frame("t5", 0, 8'h00, 8'h55);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc14500b_trace_uart.md
Name: mc14500b_trace_uart

Overview:
- Consumer end of the mc14500b_demo OUTPUT/TRACE interface.
- Watches the demo's OUTPUT and TRACE buses and records every change of their combined value into a small FIFO.
- Streams each record off-chip as framed UART bytes.
- Sits beside mc14500b_demo on the iCE40 board top, so demo execution can be observed on a PC without a simulator.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 16, record slots; power of two, >= 2.
- SYNC_BYTE, 8'hA5, first byte of every record frame.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  capture enable; when low, no samples are taken and the transmitter keeps draining.
- OUTPUT  input  8  demo OUTPUT bus; synchronous to CLK.
- TRACE  input  8  demo TRACE bus; synchronous to CLK.
- TX  output  1  UART serial out: 8N1, LSB first, idle high.
- BUSY  output  1  high while the FIFO is non-empty or a frame is in flight.
- OVERFLOW  output  1  sticky: a record was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - TX=1, BUSY=0, OVERFLOW=0.
  - FIFO empty; FSM in IDLE.
  - first_flag=1; last-sample register cleared to 0.
- Capture, on each CLK edge with EN=1:
  - sample S={OUTPUT,TRACE}.
  - If first_flag=1 or S != last: push S, set last=S, clear first_flag.
  - If EN=0: last and first_flag hold.
- FIFO full during a push:
  - Record is dropped; last is still updated, so the change is lost rather than retried.
  - OVERFLOW is set and stays set until reset.
  - A push is rejected when full even if a pop happens on the same edge. Full is evaluated before the edge.
- Pop and push on the same edge when not full: both take effect; count unchanged.
- Frame per record: 3 bytes, in order SYNC_BYTE, OUTPUT byte, TRACE byte.
- FSM states: IDLE -> SYNC -> OUTB -> TRACEB -> IDLE.
  - IDLE with FIFO non-empty: pop the record into a holding register and load SYNC_BYTE into the byte transmitter.
  - Each subsequent state loads its byte when the byte transmitter reports done.
  - TRACEB done: return to IDLE. A back-to-back record starts with no extra gap beyond one IDLE cycle.
- Byte transmitter:
  - States: START (TX=0), DATA bits 0..7, STOP (TX=1).
  - Each state lasts exactly CLKS_PER_BIT cycles, so one byte = 10*CLKS_PER_BIT cycles.
  - done pulses one cycle at the end of STOP.
- Latency from idle: change sampled at edge k is written to the FIFO at edge k. The FSM pops at edge k+1. TX falls at edge k+2.
- BUSY = FIFO non-empty OR FSM != IDLE OR byte transmitter active; registered.
- Reset mid-frame: TX returns high immediately (async); the partial frame is abandoned.
- Bit counter and FIFO pointers wrap naturally. Pointers are log2(FIFO_DEPTH)+1 bits, using the MSB to distinguish full from empty.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - A free-running 16-bit cycle counter (reset 0, wraps at 16'hFFFF -> 0) is captured with each record.
  - FIFO entries widen to 32 bits.
  - Frame becomes 5 bytes: SYNC_BYTE, TS[15:8], TS[7:0], OUTPUT, TRACE.
  - FSM gains states TSH and TSL between SYNC and OUTB.
- Undefined: no counter; 3-byte frames exactly as above.

Decomposition:
- Package mc14500b_trace_pkg:
  - record_t typedef (packed OUTPUT/TRACE, plus ts under the macro).
  - FSM state enum.
  - FRAME_BYTES localparam (3 or 5).
- Sub-module uart_tx_byte (CLKS_PER_BIT parameter):
  - Ports: CLK, RST, data[7:0], start, TX, busy, done.
  - Instantiated once; FIFO and capture logic stay inline.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset then EN=1, OUTPUT=8'h00, TRACE=8'h00 held -> exactly one frame A5 00 00 (first-sample rule). TX low 2 cycles after the first sample edge. Each bit 4 cycles; BUSY drops after 120 cycles.
- Step OUTPUT to 8'h3C, TRACE to 8'h81 for one cycle each, 10 cycles apart, starting from 00/00 -> frames A5 3C 00, then A5 3C 81, back-to-back. No frame for unchanged cycles.
- 6 distinct changes on consecutive cycles while idle -> the first is popped immediately, the next 4 fill the FIFO, the 6th is dropped. OVERFLOW=1 and stays 1 after draining. Exactly 5 frames are emitted.
- EN=0 while the inputs toggle, then EN=1 with the inputs equal to last -> no frame. A later change emits a frame.
- Assert RST during the OUTB byte -> TX=1 in the same cycle, BUSY=0. After release, the next sample emits a fresh full frame starting with A5.
- With TRACE_TIMESTAMP_EN: first sample at counter value 16'h0005 -> frame A5 00 05 00 00.
